// File: rtl/load_store_unit.sv
// load_store_unit: RV64 byte/half/word/double loads and stores onto a 64-bit word memory.
// Define LSU_PERF_CNT_EN to add the saturating ld_cnt / st_cnt / err_cnt outputs.
module load_store_unit #(
  parameter int SD_DIRECT = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  output logic             resp_valid,
  output logic [63:0]      resp_rdata,
  output logic             resp_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  input  logic [63:0]      mem_rdata
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ld_cnt,
  output logic [CNT_W-1:0] st_cnt,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ST_RD,
    S_ST_WR,
    S_DONE
  } state_t;

  state_t      state;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [63:0] resp_rdata_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;

  logic [2:0]  lane_p0;
  logic [2:0]  f3_p0;
  logic [63:0] wdata_p0;

  logic        accept;
  logic        acc_err;
  logic        acc_sd_direct;

  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend by funct3.
  function automatic logic [63:0] load_extend(input logic [63:0] dword,
                                              input logic [2:0]  lane,
                                              input logic [2:0]  f3);
    logic        [63:0] sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    logic signed [63:0] r_s;
    sh  = dword >> {lane, 3'b000};
    b_s = $signed(sh[7:0]);
    h_s = $signed(sh[15:0]);
    w_s = $signed(sh[31:0]);
    case (f3)
      3'b000:  r_s = 64'(b_s);
      3'b001:  r_s = 64'(h_s);
      3'b010:  r_s = 64'(w_s);
      3'b100:  r_s = $signed({56'd0, sh[7:0]});
      3'b101:  r_s = $signed({48'd0, sh[15:0]});
      3'b110:  r_s = $signed({32'd0, sh[31:0]});
      default: r_s = $signed(sh);
    endcase
    return $unsigned(r_s);
  endfunction

  function automatic logic [63:0] store_merge(input logic [63:0] old_dw,
                                              input logic [63:0] wd,
                                              input logic [2:0]  lane,
                                              input logic [1:0]  sz);
    logic [7:0]  mask;
    logic [63:0] sh;
    logic [63:0] r;
    mask = byte_mask(sz) << lane;
    sh   = wd << {lane, 3'b000};
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = mask[i] ? sh[8*i +: 8] : old_dw[8*i +: 8];
    end
    return r;
  endfunction

  assign req_ready     = (state == S_IDLE) && !reset;
  assign accept        = req_valid && req_ready;
  assign acc_err       = ((req_addr[2:0] & align_mask(req_funct3[1:0])) != 3'd0)
                      || (req_write && req_funct3[2])
                      || (!req_write && (req_funct3 == 3'b111));
  assign acc_sd_direct = (SD_DIRECT != 0) && (req_funct3 == 3'b011);

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_read   = mem_read_q;
  // Combinational gate so a reset arriving in the write cycle blocks the write.
  assign mem_write  = mem_write_q && !reset;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Stage p0: request fields captured on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      lane_p0  <= req_addr[2:0];
      f3_p0    <= req_funct3;
      wdata_p0 <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 64'd0;
      mem_wdata_q  <= 64'd0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (acc_err) begin
              state        <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_write) begin
              state      <= S_LOAD;
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_addr[63:3], 3'b000};
            end else if (acc_sd_direct) begin
              state       <= S_ST_WR;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {req_addr[63:3], 3'b000};
              mem_wdata_q <= req_wdata;
            end else begin
              state      <= S_ST_RD;
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_addr[63:3], 3'b000};
            end
          end
        end
        S_LOAD: begin
          resp_rdata_q <= load_extend(mem_rdata, lane_p0, f3_p0);
          mem_read_q   <= 1'b0;
          mem_addr_q   <= 64'd0;
          resp_valid_q <= 1'b1;
          state        <= S_DONE;
        end
        S_ST_RD: begin
          mem_wdata_q <= store_merge(mem_rdata, wdata_p0, lane_p0, f3_p0[1:0]);
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          state       <= S_ST_WR;
        end
        S_ST_WR: begin
          mem_write_q  <= 1'b0;
          mem_addr_q   <= 64'd0;
          mem_wdata_q  <= 64'd0;
          resp_valid_q <= 1'b1;
          state        <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic write_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0 <= req_write;
    end
  end

  // Stage done: classify the finished request exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt  <= '0;
      st_cnt  <= '0;
      err_cnt <= '0;
    end else if (state == S_DONE) begin
      if (resp_err_q) begin
        err_cnt <= sat_inc(err_cnt);
      end else if (write_p0) begin
        st_cnt <= sat_inc(st_cnt);
      end else begin
        ld_cnt <= sat_inc(ld_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory model, per-cycle output compare, directed + random requests.
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int SD_DIRECT = 1;
  localparam int CNT_W     = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef LSU_PERF_CNT_EN
  logic [CNT_W-1:0] ld_cnt, st_cnt, err_cnt;
`endif

  load_store_unit #(.SD_DIRECT(SD_DIRECT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef LSU_PERF_CNT_EN
    , .ld_cnt(ld_cnt), .st_cnt(st_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Data memory: 32 doublewords, upper address bits alias.
  logic [63:0] mem [0:31] = '{default: 64'd0};
  assign mem_rdata = mem[mem_addr[7:3]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:3]] <= mem_wdata;

  // Reference model: byte array with the same aliasing.
  logic [7:0]  refmem [0:255] = '{default: 8'd0};
  int          cyc = 0;
  int          acc_c, exp_resp_c, exp_rd_c, exp_wr_c;
  logic [63:0] exp_maddr, exp_wword, model_rdata;
  logic        exp_err;
  int          m_ld, m_st, m_er;
  int          nvec = 0, nfail = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    acc_c = -100; exp_resp_c = -100; exp_rd_c = -100; exp_wr_c = -100;
    exp_maddr = 64'd0; exp_wword = 64'd0; exp_err = 1'b0; model_rdata = 64'd0;
    m_ld = 0; m_st = 0; m_er = 0;
  endtask

  // Called in the cycle the request is presented with ready high.
  task automatic model_accept(input logic w, input logic [2:0] f3, input logic [63:0] a,
                              input logic [63:0] wd);
    int          size, base, idx;
    logic [63:0] v;
    size = 1 << f3[1:0];
    acc_c = cyc; exp_rd_c = -100; exp_wr_c = -100;
    exp_maddr = a & ~64'h7;
    exp_err = ((a % size) != 0) || (w && f3[2]) || (!w && f3 == 3'd7);
    if (exp_err) begin
      exp_resp_c = cyc + 1;
      m_er++;
    end else if (!w) begin
      v = 64'd0;
      for (int i = 0; i < size; i++) begin
        idx = (int'(a[7:0]) + i) & 255;
        v = v | (64'(refmem[idx]) << (8 * i));
      end
      if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8 * size));
      model_rdata = v;
      exp_rd_c = cyc + 1;
      exp_resp_c = cyc + 2;
      m_ld++;
    end else begin
      for (int i = 0; i < size; i++) begin
        idx = (int'(a[7:0]) + i) & 255;
        refmem[idx] = wd[8*i +: 8];
      end
      base = int'(a[7:0]) & 248;
      exp_wword = 64'd0;
      for (int i = 0; i < 8; i++) exp_wword = exp_wword | (64'(refmem[base + i]) << (8 * i));
      if (f3 == 3'd3 && SD_DIRECT != 0) begin
        exp_wr_c = cyc + 1;
        exp_resp_c = cyc + 2;
      end else begin
        exp_rd_c = cyc + 1;
        exp_wr_c = cyc + 2;
        exp_resp_c = cyc + 3;
      end
      m_st++;
    end
  endtask

  // Per-cycle comparison of every output against the model's schedule.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("resp_valid", 64'(resp_valid), 64'(cyc == exp_resp_c));
      chk("req_ready", 64'(req_ready), 64'(!(cyc > acc_c && cyc <= exp_resp_c)));
      chk("mem_read", 64'(mem_read), 64'(cyc == exp_rd_c));
      chk("mem_write", 64'(mem_write), 64'(cyc == exp_wr_c));
      chk("mem_addr", mem_addr, (cyc == exp_rd_c || cyc == exp_wr_c) ? exp_maddr : 64'd0);
      chk("mem_wdata", mem_wdata, (cyc == exp_wr_c) ? exp_wword : 64'd0);
      if (cyc == exp_resp_c) begin
        chk("resp_err", 64'(resp_err), 64'(exp_err));
        chk("resp_rdata", resp_rdata, model_rdata);
      end else begin
        chk("resp_err_idle", 64'(resp_err), 64'd0);
      end
    end
  end

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, output logic [63:0] rd, output logic er,
                        output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (!req_ready) begin
      nfail++;
      $display("FAIL ready_timeout cyc=%0d got=0 expected=1", cyc);
    end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    model_accept(w, f3, a, wd);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 10);
    rd = resp_rdata;
    er = resp_err;
    nvec++;
    if (!resp_valid) begin
      nfail++;
      $display("FAIL resp_timeout cyc=%0d got=0 expected=1", cyc);
    end
  endtask

  initial begin
    logic [63:0] rd, a, wd;
    logic        er, w;
    logic [2:0]  f3;
    int          lat;
    logic [7:0]  snap [0:7];

    clear_model();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    do_req(1'b1, 3'd3, 64'h10, 64'h1122334455667788, rd, er, lat);
    chk("sd10_lat", 64'(lat), 64'd2);
    chk("sd10_err", 64'(er), 64'd0);
    do_req(1'b0, 3'd0, 64'h10, 64'd0, rd, er, lat);
    chk("lb10", rd, 64'hFFFF_FFFF_FFFF_FF88);
    chk("lb10_lat", 64'(lat), 64'd2);
    do_req(1'b0, 3'd0, 64'h17, 64'd0, rd, er, lat);
    chk("lb17", rd, 64'h11);
    do_req(1'b0, 3'd5, 64'h12, 64'd0, rd, er, lat);
    chk("lhu12", rd, 64'h5566);
    do_req(1'b0, 3'd2, 64'h14, 64'd0, rd, er, lat);
    chk("lw14", rd, 64'h0000_0000_1122_3344);
    chk("lw14_lat", 64'(lat), 64'd2);

    do_req(1'b1, 3'd0, 64'h13, 64'hAB, rd, er, lat);
    chk("sb13_lat", 64'(lat), 64'd3);
    do_req(1'b0, 3'd3, 64'h10, 64'd0, rd, er, lat);
    chk("ld10", rd, 64'h1122_3344_AB66_7788);

    do_req(1'b0, 3'd2, 64'h12, 64'd0, rd, er, lat);
    chk("lw12_err", 64'(er), 64'd1);
    chk("lw12_lat", 64'(lat), 64'd1);
    chk("lw12_rdata_kept", rd, 64'h1122_3344_AB66_7788);
    do_req(1'b1, 3'd1, 64'h11, 64'h1234, rd, er, lat);
    chk("sh11_err", 64'(er), 64'd1);
    do_req(1'b1, 3'd4, 64'h10, 64'hFF, rd, er, lat);
    chk("st_f3_4_err", 64'(er), 64'd1);
    chk("st_f3_4_lat", 64'(lat), 64'd1);

    // Reset during the write cycle of an RMW store.
    do_req(1'b1, 3'd3, 64'h18, 64'hCAFE_F00D_1234_5678, rd, er, lat);
    for (int i = 0; i < 8; i++) snap[i] = refmem[24 + i];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1; req_addr = 64'h18; req_wdata = 64'hBEEF;
    model_accept(1'b1, 3'd1, 64'h18, 64'hBEEF);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_wr_gate", 64'(mem_write), 64'd0);
    chk("rst_wr_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 8; i++) refmem[24 + i] = snap[i];
    chk_en = 1'b1;
    #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    chk("rdata_after_rst", resp_rdata, 64'd0);
`ifdef LSU_PERF_CNT_EN
    chk("cnt_after_rst", 64'(ld_cnt) | 64'(st_cnt) | 64'(err_cnt), 64'd0);
`endif
    do_req(1'b0, 3'd3, 64'h18, 64'd0, rd, er, lat);
    chk("ld18_unchanged", rd, 64'hCAFE_F00D_1234_5678);

    for (int k = 0; k < 300; k++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[63:8] = 56'd0;
      if ($urandom_range(0, 1) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      wd = {$urandom, $urandom};
      do_req(w, f3, a, wd, rd, er, lat);
    end

    @(negedge clk);
    for (int j = 0; j < 32; j++) begin
      wd = 64'd0;
      for (int i = 0; i < 8; i++) wd = wd | (64'(refmem[8*j + i]) << (8 * i));
      chk("final_mem", mem[j], wd);
    end
`ifdef LSU_PERF_CNT_EN
    chk("ld_cnt", 64'(ld_cnt), 64'(m_ld));
    chk("st_cnt", 64'(st_cnt), 64'(m_st));
    chk("err_cnt", 64'(err_cnt), 64'(m_er));
`endif
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
